// File: rtl/multicycle_control_if.sv
// Bus between the multicycle control FSM and the decode/exec/mem/PC datapath.
// MCCTRL_ILLEGAL_TRAP_EN adds the Illegal status output.
interface multicycle_control_if #(parameter int ALU_FUNC_W = 4);
    logic [31:0]           Instr;
    logic                  ALU_zero;
    logic                  IR_LdEn;
    logic                  PC_LdEn;
    logic                  PC_sel;
    logic                  RF_B_sel;
    logic                  RF_WrEn;
    logic                  RF_WrData_sel;
    logic                  ALU_Bin_sel;
    logic [ALU_FUNC_W-1:0] ALU_func;
    logic                  Mem_WrEn;
    logic                  ByteOp;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    logic                  Illegal;

    modport master (input Instr, ALU_zero,
                    output IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
                           ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp, Illegal);
    modport slave  (output Instr, ALU_zero,
                    input  IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
                           ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp, Illegal);
`else
    modport master (input Instr, ALU_zero,
                    output IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
                           ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp);
    modport slave  (output Instr, ALU_zero,
                    input  IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
                           ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp);
`endif
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing for the datapath.
// Optional MCCTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT instead of acting as nop.
module multicycle_control #(
    parameter int MEM_LATENCY = 1,
    parameter int ALU_FUNC_W  = 4
) (
    input  logic Clk,
    input  logic Reset,
    multicycle_control_if.master bus
);

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_IFETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_HALT
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IFETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH
    } state_t;
`endif

    typedef struct packed {
        logic                  ir_ld;
        logic                  pc_ld;
        logic                  pc_sel;
        logic                  rf_b_sel;
        logic                  rf_wr;
        logic                  rf_wd_sel;
        logic                  alu_bin_sel;
        logic [ALU_FUNC_W-1:0] alu_func;
        logic                  mem_wr;
        logic                  byte_op;
    } ctrl_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      o;

    logic [5:0] op;
    logic is_r, is_li, is_lui, is_addi, is_andi, is_ori;
    logic is_lb, is_lw, is_sb, is_sw, is_b, is_beq, is_bne;
    logic is_load, is_store, is_byte, is_branch, is_exec;
    logic unused_instr;

    assign op           = bus.Instr[31:26];
    assign unused_instr = ^bus.Instr[25:4];

    assign is_r      = (op == 6'b100000);
    assign is_li     = (op == 6'b111000);
    assign is_lui    = (op == 6'b111001);
    assign is_addi   = (op == 6'b110000);
    assign is_andi   = (op == 6'b110010);
    assign is_ori    = (op == 6'b110011);
    assign is_lb     = (op == 6'b000011);
    assign is_lw     = (op == 6'b001111);
    assign is_sb     = (op == 6'b000111);
    assign is_sw     = (op == 6'b011111);
    assign is_b      = (op == 6'b111111);
    assign is_beq    = (op == 6'b000000);
    assign is_bne    = (op == 6'b000001);
    assign is_load   = is_lb | is_lw;
    assign is_store  = is_sb | is_sw;
    assign is_byte   = is_lb | is_sb;
    assign is_branch = is_b | is_beq | is_bne;
    assign is_exec   = is_r | is_li | is_lui | is_addi | is_andi | is_ori | is_load | is_store;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IFETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        o       = '0;
        case (state_q)
            S_IFETCH: begin
                o.ir_ld = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                o.rf_b_sel = is_store | is_beq | is_bne;
                if (is_branch)    state_d = S_BRANCH;
                else if (is_exec) state_d = S_EXEC;
                else begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    o.pc_ld = 1'b1;
                    state_d = S_IFETCH;
`endif
                end
            end
            S_EXEC: begin
                o.alu_bin_sel = ~is_r;
                o.byte_op     = is_byte;
                if (is_r)         o.alu_func = ALU_FUNC_W'(bus.Instr[3:0]);
                else if (is_andi) o.alu_func = ALU_FUNC_W'(4'b0010);
                else if (is_ori)  o.alu_func = ALU_FUNC_W'(4'b0011);
                if (is_load)       state_d = S_MEM_RD;
                else if (is_store) state_d = S_MEM_WR;
                else               state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                o.rf_wr = 1'b1;
                o.pc_ld = 1'b1;
                state_d = S_IFETCH;
            end
            S_MEM_RD: begin
                o.byte_op = is_byte;
                if (cnt_q == CNT_LAST) state_d = S_MEM_WB;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_MEM_WR: begin
                o.mem_wr  = 1'b1;
                o.byte_op = is_byte;
                // Write strobe spans the whole latency; PC advances with the final beat.
                if (cnt_q == CNT_LAST) begin
                    o.pc_ld = 1'b1;
                    state_d = S_IFETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_MEM_WB: begin
                o.rf_wr     = 1'b1;
                o.rf_wd_sel = 1'b1;
                o.pc_ld     = 1'b1;
                o.byte_op   = is_byte;
                state_d     = S_IFETCH;
            end
            S_BRANCH: begin
                o.alu_func = ALU_FUNC_W'(4'b0001);
                o.rf_b_sel = 1'b1;
                o.pc_ld    = 1'b1;
                o.pc_sel   = is_b | (is_beq & bus.ALU_zero) | (is_bne & ~bus.ALU_zero);
                state_d    = S_IFETCH;
            end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IFETCH;
        endcase
        // Outputs are quiet while reset is held, so an aborted instruction writes nothing.
        if (Reset) o = '0;
    end

    assign bus.IR_LdEn       = o.ir_ld;
    assign bus.PC_LdEn       = o.pc_ld;
    assign bus.PC_sel        = o.pc_sel;
    assign bus.RF_B_sel      = o.rf_b_sel;
    assign bus.RF_WrEn       = o.rf_wr;
    assign bus.RF_WrData_sel = o.rf_wd_sel;
    assign bus.ALU_Bin_sel   = o.alu_bin_sel;
    assign bus.ALU_func      = o.alu_func;
    assign bus.Mem_WrEn      = o.mem_wr;
    assign bus.ByteOp        = o.byte_op;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign bus.Illegal       = (state_q == S_HALT) & ~Reset;
`endif

endmodule
